// File: rtl/sat_pkg.sv
// Shared SAT datapath package: literal geometry, null-variable encoding and
// the issuer FSM state type. Also imported by the FIFO tree and break-value stage.
package sat_pkg;

  localparam int LIT_WIDTH       = 12;
  localparam int LITS_PER_CLAUSE = 3;
  localparam int CLAUSE_WIDTH    = LIT_WIDTH * LITS_PER_CLAUSE;

  // Literal layout: sign in the MSB (1 = negated), variable index below it.
  localparam int SIGN_BIT = LIT_WIDTH - 1;
  localparam int VAR_W    = LIT_WIDTH - 1;

  // Variable index 0 marks a padding slot that is never issued.
  localparam logic [VAR_W-1:0] NULL_VAR = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_FINISH
  } issuer_state_e;

endpackage

// File: rtl/clause_lit_mux.sv
// Combinational slot selector for one clause: returns the literal at the
// pointer, the next non-null slot above it, and whether none remains.
// A pointer value of LITS_PER_CLAUSE means "no slot".
module clause_lit_mux #(
  parameter int LIT_WIDTH       = 12,
  parameter int LITS_PER_CLAUSE = 3,
  parameter int CLAUSE_WIDTH    = LIT_WIDTH * LITS_PER_CLAUSE,
  parameter int PTR_W           = $clog2(LITS_PER_CLAUSE + 1)
) (
  input  logic [CLAUSE_WIDTH-1:0] clause_i,
  input  logic [PTR_W-1:0]        ptr_i,
  output logic [LIT_WIDTH-1:0]    lit_o,
  output logic [PTR_W-1:0]        nxt_o,
  output logic                    last_o
);
  import sat_pkg::*;

  // Scan high to low so the lowest qualifying slot wins.
  always_comb begin
    lit_o = '0;
    nxt_o = PTR_W'(LITS_PER_CLAUSE);
    for (int k = LITS_PER_CLAUSE - 1; k >= 0; k--) begin
      if (PTR_W'(k) == ptr_i) begin
        lit_o = clause_i[k*LIT_WIDTH +: LIT_WIDTH];
      end
      if ((PTR_W'(k) > ptr_i) &&
          (clause_i[k*LIT_WIDTH +: LIT_WIDTH-1] != (LIT_WIDTH-1)'(NULL_VAR))) begin
        nxt_o = PTR_W'(k);
      end
    end
    last_o = (nxt_o == PTR_W'(LITS_PER_CLAUSE));
  end

endmodule

// File: rtl/clause_literal_issuer.sv
// Drains the unsatisfied-clause FIFO tree on start, splits each clause into
// literals and streams the non-null ones on a valid/ready interface.
// Optional statistics counters: define CLAUSE_ISSUER_STATS_EN.
module clause_literal_issuer #(
  parameter int CLAUSE_WIDTH    = 36,
  parameter int LITS_PER_CLAUSE = 3,
  parameter int LIT_WIDTH       = 12,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic                    fifo_empty_i,
  input  logic                    fifo_of_i,
  input  logic [CLAUSE_WIDTH-1:0] fifo_clause_i,
  output logic                    fifo_rden_o,
  output logic                    fifo_cof_o,
  output logic [LIT_WIDTH-1:0]    lit_o,
  output logic                    lit_valid_o,
  input  logic                    lit_ready_i,
  output logic                    lit_last_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    of_seen_o
`ifdef CLAUSE_ISSUER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]    clauses_popped_o,
  output logic [CNT_WIDTH-1:0]    lits_issued_o
`endif
);
  import sat_pkg::*;

  localparam int PTR_W = $clog2(LITS_PER_CLAUSE + 1);
  localparam logic [PTR_W-1:0] PTR_NONE = PTR_W'(LITS_PER_CLAUSE);

  if ((CLAUSE_WIDTH != LITS_PER_CLAUSE * LIT_WIDTH) || (CNT_WIDTH < 1)) begin : g_bad_cfg
    $error("clause_literal_issuer: inconsistent width parameters");
  end

  issuer_state_e             state_q, state_d;
  logic [CLAUSE_WIDTH-1:0]   clause_q, clause_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic                      of_seen_q, of_seen_d;
  logic [PTR_W-1:0]          first_ptr;
  logic [LIT_WIDTH-1:0]      mux_lit;
  logic [PTR_W-1:0]          mux_nxt;
  logic                      mux_last;
  logic                      lit_valid;

  clause_lit_mux #(
    .LIT_WIDTH      (LIT_WIDTH),
    .LITS_PER_CLAUSE(LITS_PER_CLAUSE),
    .CLAUSE_WIDTH   (CLAUSE_WIDTH),
    .PTR_W          (PTR_W)
  ) u_mux (
    .clause_i(clause_q),
    .ptr_i   (ptr_q),
    .lit_o   (mux_lit),
    .nxt_o   (mux_nxt),
    .last_o  (mux_last)
  );

  // Lowest non-null slot of the clause arriving from the tree.
  always_comb begin
    first_ptr = PTR_NONE;
    for (int k = LITS_PER_CLAUSE - 1; k >= 0; k--) begin
      if (fifo_clause_i[k*LIT_WIDTH +: LIT_WIDTH-1] != (LIT_WIDTH-1)'(NULL_VAR)) begin
        first_ptr = PTR_W'(k);
      end
    end
  end

  // State, clause, pointer and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      clause_q  <= '0;
      ptr_q     <= '0;
      of_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clause_q  <= clause_d;
      ptr_q     <= ptr_d;
      of_seen_q <= of_seen_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    clause_d    = clause_q;
    ptr_d       = ptr_q;
    of_seen_d   = of_seen_q;
    fifo_rden_o = 1'b0;
    fifo_cof_o  = 1'b0;
    done_o      = 1'b0;
    lit_valid   = 1'b0;

    if ((state_q != S_IDLE) && fifo_of_i) begin
      of_seen_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          of_seen_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (!fifo_empty_i) begin
          fifo_rden_o = 1'b1;
          state_d     = S_WAIT;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_WAIT: begin
        clause_d = fifo_clause_i;
        ptr_d    = first_ptr;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        if (ptr_q == PTR_NONE) begin
          state_d = S_REQ;
        end else begin
          lit_valid = 1'b1;
          if (lit_ready_i) begin
            if (mux_last) begin
              state_d = S_REQ;
            end else begin
              ptr_d = mux_nxt;
            end
          end
        end
      end
      S_FINISH: begin
        done_o     = 1'b1;
        fifo_cof_o = of_seen_q | fifo_of_i;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign lit_valid_o = lit_valid;
  assign lit_o       = lit_valid ? mux_lit : '0;
  assign lit_last_o  = lit_valid & mux_last;
  assign of_seen_o   = of_seen_q;

`ifdef CLAUSE_ISSUER_STATS_EN
  logic [CNT_WIDTH-1:0] popped_q, popped_d;
  logic [CNT_WIDTH-1:0] issued_q, issued_d;

  // Saturating counters, restarted by every accepted start.
  always_comb begin
    popped_d = popped_q;
    issued_d = issued_q;
    if ((state_q == S_IDLE) && start_i) begin
      popped_d = '0;
      issued_d = '0;
    end else begin
      if (fifo_rden_o && (popped_q != '1)) popped_d = popped_q + 1'b1;
      if (lit_valid && lit_ready_i && (issued_q != '1)) issued_d = issued_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      popped_q <= '0;
      issued_q <= '0;
    end else begin
      popped_q <= popped_d;
      issued_q <= issued_d;
    end
  end

  assign clauses_popped_o = popped_q;
  assign lits_issued_o    = issued_q;
`endif

endmodule

// File: tb/tb_clause_literal_issuer.sv
// Directed bench for clause_literal_issuer with a behavioural FIFO-tree model.
// Build with CLAUSE_ISSUER_STATS_EN defined to also check the counters.
module tb_clause_literal_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        fifo_empty_i = 1'b1;
  logic        fifo_of_i;
  logic [35:0] fifo_clause_i = '0;
  logic        fifo_rden_o;
  logic        fifo_cof_o;
  logic [11:0] lit_o;
  logic        lit_valid_o;
  logic        lit_ready_i;
  logic        lit_last_o;
  logic        busy_o;
  logic        done_o;
  logic        of_seen_o;
`ifdef CLAUSE_ISSUER_STATS_EN
  logic [15:0] clauses_popped_o;
  logic [15:0] lits_issued_o;
`endif

  int nerr = 0;
  int nchk = 0;

  logic [35:0] fifo_q[$];
  logic [11:0] got_lit[$];
  logic        got_last[$];
  int          done_cnt = 0;
  int          cof_cnt = 0;
  int          cof_done_cnt = 0;

  clause_literal_issuer dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_of_i    (fifo_of_i),
    .fifo_clause_i(fifo_clause_i),
    .fifo_rden_o  (fifo_rden_o),
    .fifo_cof_o   (fifo_cof_o),
    .lit_o        (lit_o),
    .lit_valid_o  (lit_valid_o),
    .lit_ready_i  (lit_ready_i),
    .lit_last_o   (lit_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .of_seen_o    (of_seen_o)
`ifdef CLAUSE_ISSUER_STATS_EN
    ,
    .clauses_popped_o(clauses_popped_o),
    .lits_issued_o   (lits_issued_o)
`endif
  );

  always #5 clk = ~clk;

  // FIFO tree model: a read delivers the head clause the following cycle.
  always @(posedge clk) begin
    if (fifo_rden_o && (fifo_q.size() > 0)) begin
      fifo_clause_i <= fifo_q.pop_front();
    end
    fifo_empty_i <= (fifo_q.size() == 0);
  end

  // Stream and pulse monitor.
  always @(posedge clk) begin
    if (lit_valid_o && lit_ready_i) begin
      got_lit.push_back(lit_o);
      got_last.push_back(lit_last_o);
    end
    if (done_o) done_cnt <= done_cnt + 1;
    if (fifo_cof_o) cof_cnt <= cof_cnt + 1;
    if (fifo_cof_o && done_o) cof_done_cnt <= cof_done_cnt + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int  base_done, base_cof, base_cofd, base_hs, nlast;
  bit  found;

  initial begin
    reset = 1'b0; start_i = 1'b1; lit_ready_i = 1'b0; fifo_of_i = 1'b0;
    fifo_q.push_back(36'h123456789);
    cyc(); cyc(); cyc();
    // Reset with start high and a non-empty tree
    check("rst_rden", fifo_rden_o, 0);
    check("rst_cof", fifo_cof_o, 0);
    check("rst_lit", lit_o, 0);
    check("rst_valid", lit_valid_o, 0);
    check("rst_last", lit_last_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_of_seen", of_seen_o, 0);
    start_i = 1'b0;
    fifo_q.delete();
    cyc();
    reset = 1'b1; lit_ready_i = 1'b1;
    cyc();

    // Three-literal clause with ready high
    fifo_q.push_back(36'h801002003);
    cyc();
    start_i = 1'b1; cyc(); start_i = 1'b0;
    check("A_req_rden", fifo_rden_o, 1);
    check("A_req_busy", busy_o, 1);
    cyc();
    check("A_wait_rden", fifo_rden_o, 0);
    check("A_wait_valid", lit_valid_o, 0);
    cyc();
    check("A_lit0", {lit_valid_o, lit_last_o, lit_o}, {2'b10, 12'h003});
    cyc();
    check("A_lit1", {lit_valid_o, lit_last_o, lit_o}, {2'b10, 12'h002});
    cyc();
    check("A_lit2", {lit_valid_o, lit_last_o, lit_o}, {2'b11, 12'h801});
    cyc();
    check("A_req2_rden", fifo_rden_o, 0);
    check("A_req2_valid", lit_valid_o, 0);
    cyc();
    check("A_done", done_o, 1);
    check("A_no_cof", fifo_cof_o, 0);
    cyc();
    check("A_idle_busy", busy_o, 0);
    check("A_idle_done", done_o, 0);
    check("A_hs_count", got_lit.size(), 3);
    if (got_lit.size() == 3) begin
      check("A_hs0", {got_last[0], got_lit[0]}, {1'b0, 12'h003});
      check("A_hs1", {got_last[1], got_lit[1]}, {1'b0, 12'h002});
      check("A_hs2", {got_last[2], got_lit[2]}, {1'b1, 12'h801});
    end
    got_lit.delete(); got_last.delete();

    // Single middle literal, then an all-null clause
    fifo_q.push_back(36'h000005000);
    fifo_q.push_back(36'h000000000);
    cyc();
    start_i = 1'b1; cyc(); start_i = 1'b0;
    check("B_req_rden", fifo_rden_o, 1);
    cyc(); cyc();
    check("B_lit", {lit_valid_o, lit_last_o, lit_o}, {2'b11, 12'h005});
    cyc();
    check("B_req2_rden", fifo_rden_o, 1);
    cyc();
    check("B_wait2_valid", lit_valid_o, 0);
    cyc();
    check("B_null_issue_valid", lit_valid_o, 0);
    check("B_null_issue_busy", busy_o, 1);
    cyc();
    check("B_req3_rden", fifo_rden_o, 0);
    check("B_req3_busy", busy_o, 1);
    cyc();
    check("B_done", done_o, 1);
    cyc();
    check("B_hs_count", got_lit.size(), 1);
    got_lit.delete(); got_last.delete();

    // Ready stall pattern 1-0-0-1 (-1 for the final literal)
    fifo_q.push_back(36'h00A00B00C);
    cyc();
    start_i = 1'b1; cyc(); start_i = 1'b0;
    cyc(); cyc();
    check("C_lit0", {lit_valid_o, lit_o}, {1'b1, 12'h00C});
    cyc();
    lit_ready_i = 1'b0;
    check("C_lit1_a", {lit_valid_o, lit_last_o, lit_o}, {2'b10, 12'h00B});
    cyc();
    check("C_lit1_stall", {lit_valid_o, lit_last_o, lit_o}, {2'b10, 12'h00B});
    cyc();
    lit_ready_i = 1'b1;
    check("C_lit1_stall2", {lit_valid_o, lit_last_o, lit_o}, {2'b10, 12'h00B});
    cyc();
    check("C_lit2", {lit_valid_o, lit_last_o, lit_o}, {2'b11, 12'h00A});
    cyc(); cyc();
    check("C_done", done_o, 1);
    check("C_hs_count", got_lit.size(), 3);
    if (got_lit.size() == 3) begin
      check("C_order", {got_lit[0], got_lit[1], got_lit[2]}, {12'h00C, 12'h00B, 12'h00A});
    end
    cyc();
    got_lit.delete(); got_last.delete();

    // Four-clause drain with an overflow pulse and a mid-drain start
    fifo_q.push_back(36'h003002001);
    fifo_q.push_back(36'h006005004);
    fifo_q.push_back(36'h009008007);
    fifo_q.push_back(36'h00C00B00A);
    cyc();
    base_done = done_cnt; base_cof = cof_cnt; base_cofd = cof_done_cnt;
    start_i = 1'b1; cyc(); start_i = 1'b0;
    found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (done_o) found = 1;
      else begin
        fifo_of_i = (i == 4);
        start_i   = (i == 8);
        cyc();
      end
    end
    fifo_of_i = 1'b0; start_i = 1'b0;
    check("D_done_reached", found, 1);
    check("D_of_seen", of_seen_o, 1);
    check("D_cof_at_done", fifo_cof_o, 1);
    cyc(); cyc(); cyc(); cyc(); cyc();
    check("D_done_once", done_cnt - base_done, 1);
    check("D_cof_once", cof_cnt - base_cof, 1);
    check("D_cof_with_done", cof_done_cnt - base_cofd, 1);
    check("D_hs_count", got_lit.size(), 12);
    nlast = 0;
    foreach (got_last[k]) if (got_last[k]) nlast++;
    check("D_last_count", nlast, 4);
    check("D_idle", busy_o, 0);
    check("D_of_seen_held", of_seen_o, 1);
`ifdef CLAUSE_ISSUER_STATS_EN
    check("D_stat_clauses", clauses_popped_o, 4);
    check("D_stat_lits", lits_issued_o, 12);
`endif
    got_lit.delete(); got_last.delete();

    // Drain without overflow: sticky flag cleared by start, no cOF
    fifo_q.push_back(36'h000000001);
    cyc();
    base_cof = cof_cnt;
    start_i = 1'b1; cyc(); start_i = 1'b0;
    check("E_of_cleared", of_seen_o, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (done_o) found = 1;
      else cyc();
    end
    check("E_done_reached", found, 1);
    check("E_no_cof", fifo_cof_o, 0);
    cyc();
    check("E_cof_count", cof_cnt - base_cof, 0);
    got_lit.delete(); got_last.delete();

    // Reset mid-drain with overflow seen: no cOF, no done
    fifo_q.push_back(36'h003002001);
    cyc();
    base_done = done_cnt; base_cof = cof_cnt;
    start_i = 1'b1; cyc(); start_i = 1'b0;
    fifo_of_i = 1'b1; cyc(); fifo_of_i = 1'b0; cyc();
    check("F_issuing", lit_valid_o, 1);
    reset = 1'b0; cyc();
    check("F_rst_busy", busy_o, 0);
    check("F_rst_valid", lit_valid_o, 0);
    check("F_rst_of_seen", of_seen_o, 0);
    reset = 1'b1; cyc(); cyc(); cyc();
    check("F_no_done", done_cnt - base_done, 0);
    check("F_no_cof", cof_cnt - base_cof, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
